// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Moore FSM sequencing a multicycle CPU datapath, one instruction per 3-5
//   cycles. Opcode/Funct are sampled in DECODE and held internally so later
//   states do not depend on the instruction register. Unknown instructions
//   park the controller in TRAP (sticky Illegal) until Reset.
//
//   Every output is registered from the next-state decode, so the outputs
//   always equal a pure decode of the state register and never glitch.
//
// Optional feature (macro PERF_CNT_EN):
//   defined   : Instr_count counts retired instructions (wraps at 2^32).
//   undefined : Instr_count is tied to 0, no counter is built.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset (forces IDLE)
//   Run          in   start request, examined only in IDLE
//   Opcode[5:0]  in   instruction[31:26]
//   Funct[5:0]   in   instruction[5:0], decoded only for Opcode 0x00
//   PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst, IorD,
//   Mem_write, IR_write, ALU_src_a        out  datapath strobes
//   ALU_src_b[1:0]    out  0 reg B, 1 const 1, 2 sign-ext imm, 3 zero-ext imm
//   ALU_control[2:0]  out  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   Illegal           out  sticky trap flag
//   State[STATE_W-1:0] out current state code (debug)
//   Instr_count[31:0] out  retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  output logic               PC_write,
  output logic               Branch,
  output logic               PC_src,
  output logic               Reg_write,
  output logic               Mem_to_reg,
  output logic               Reg_dst,
  output logic               IorD,
  output logic               Mem_write,
  output logic               IR_write,
  output logic               ALU_src_a,
  output logic [1:0]         ALU_src_b,
  output logic [2:0]         ALU_control,
  output logic               Illegal,
  output logic [STATE_W-1:0] State,
  output logic [31:0]        Instr_count
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned SRC_W = 2;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [SRC_W-1:0] SRC_B_REG  = 2'd0;
  localparam logic [SRC_W-1:0] SRC_B_ONE  = 2'd1;
  localparam logic [SRC_W-1:0] SRC_B_SEXT = 2'd2;
  localparam logic [SRC_W-1:0] SRC_B_ZEXT = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = STATE_W'(0),
    S_FETCH    = STATE_W'(1),
    S_DECODE   = STATE_W'(2),
    S_EXEC_R   = STATE_W'(3),
    S_WB_R     = STATE_W'(4),
    S_MEM_ADDR = STATE_W'(5),
    S_MEM_RD   = STATE_W'(6),
    S_WB_MEM   = STATE_W'(7),
    S_MEM_WR   = STATE_W'(8),
    S_BRANCH   = STATE_W'(9),
    S_EXEC_I   = STATE_W'(10),
    S_WB_I     = STATE_W'(11),
    S_TRAP     = STATE_W'(12)
  } state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [OP_W-1:0] fn_q, fn_d;

  logic               pc_write_q,   pc_write_d;
  logic               branch_q,     branch_d;
  logic               pc_src_q,     pc_src_d;
  logic               reg_write_q,  reg_write_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic               reg_dst_q,    reg_dst_d;
  logic               iord_q,       iord_d;
  logic               mem_write_q,  mem_write_d;
  logic               ir_write_q,   ir_write_d;
  logic               alu_src_a_q,  alu_src_a_d;
  logic [SRC_W-1:0]   alu_src_b_q,  alu_src_b_d;
  logic [ALU_W-1:0]   alu_ctl_q,    alu_ctl_d;
  logic               illegal_q,    illegal_d;

  // R-type funct codes the datapath supports
  function automatic logic funct_ok(input logic [OP_W-1:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  // R-type funct to ALU operation
  function automatic logic [ALU_W-1:0] r_alu(input logic [OP_W-1:0] f);
    logic [ALU_W-1:0] a;
    a = ALU_ADD;
    case (f)
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  // State, latched opcode and latched funct
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  // Next-state logic; instruction fields are captured only in DECODE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    case (state_q)
      S_IDLE:     if (Run) state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        op_d = Opcode;
        fn_d = Funct;
        if (Opcode == OP_RTYPE)
          state_d = funct_ok(Funct) ? S_EXEC_R : S_TRAP;
        else if ((Opcode == OP_LW) || (Opcode == OP_SW))
          state_d = S_MEM_ADDR;
        else if (Opcode == OP_BEQ)
          state_d = S_BRANCH;
        else if ((Opcode == OP_ADDI) || (Opcode == OP_ORI))
          state_d = S_EXEC_I;
        else
          state_d = S_TRAP;
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_MEM_ADDR: begin
        if (op_q == OP_LW)      state_d = S_MEM_RD;
        else if (op_q == OP_SW) state_d = S_MEM_WR;
        else                    state_d = S_TRAP;
      end
      S_MEM_RD:   state_d = S_WB_MEM;
      S_WB_MEM:   state_d = S_FETCH;
      S_MEM_WR:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // Output decode of the upcoming state, registered below so the outputs
  // track the state register exactly
  always_comb begin
    pc_write_d   = 1'b0;
    branch_d     = 1'b0;
    pc_src_d     = 1'b0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_dst_d    = 1'b0;
    iord_d       = 1'b0;
    mem_write_d  = 1'b0;
    ir_write_d   = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = SRC_B_REG;
    alu_ctl_d    = ALU_AND;
    illegal_d    = 1'b0;
    case (state_d)
      S_FETCH: begin
        ir_write_d  = 1'b1;
        alu_src_a_d = 1'b1;
        alu_src_b_d = SRC_B_ONE;
        alu_ctl_d   = ALU_ADD;
        pc_write_d  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = SRC_B_SEXT;
        alu_ctl_d   = ALU_ADD;
      end
      S_EXEC_R: alu_ctl_d = r_alu(fn_d);
      S_WB_R: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_b_d = SRC_B_SEXT;
        alu_ctl_d   = ALU_ADD;
      end
      S_MEM_RD:   iord_d = 1'b1;
      S_WB_MEM: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEM_WR: begin
        iord_d      = 1'b1;
        mem_write_d = 1'b1;
      end
      S_BRANCH: begin
        alu_ctl_d = ALU_SUB;
        branch_d  = 1'b1;
        pc_src_d  = 1'b1;
      end
      S_EXEC_I: begin
        if (op_d == OP_ORI) begin
          alu_src_b_d = SRC_B_ZEXT;
          alu_ctl_d   = ALU_OR;
        end else begin
          alu_src_b_d = SRC_B_SEXT;
          alu_ctl_d   = ALU_ADD;
        end
      end
      S_WB_I:     reg_write_d = 1'b1;
      S_TRAP:     illegal_d   = 1'b1;
      default: ;
    endcase
  end

  // Output registers; reset clears every strobe at once
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_write_q   <= 1'b0;
      branch_q     <= 1'b0;
      pc_src_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_dst_q    <= 1'b0;
      iord_q       <= 1'b0;
      mem_write_q  <= 1'b0;
      ir_write_q   <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= SRC_B_REG;
      alu_ctl_q    <= ALU_AND;
      illegal_q    <= 1'b0;
    end else begin
      pc_write_q   <= pc_write_d;
      branch_q     <= branch_d;
      pc_src_q     <= pc_src_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_dst_q    <= reg_dst_d;
      iord_q       <= iord_d;
      mem_write_q  <= mem_write_d;
      ir_write_q   <= ir_write_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_ctl_q    <= alu_ctl_d;
      illegal_q    <= illegal_d;
    end
  end

  assign PC_write    = pc_write_q;
  assign Branch      = branch_q;
  assign PC_src      = pc_src_q;
  assign Reg_write   = reg_write_q;
  assign Mem_to_reg  = mem_to_reg_q;
  assign Reg_dst     = reg_dst_q;
  assign IorD        = iord_q;
  assign Mem_write   = mem_write_q;
  assign IR_write    = ir_write_q;
  assign ALU_src_a   = alu_src_a_q;
  assign ALU_src_b   = alu_src_b_q;
  assign ALU_control = alu_ctl_q;
  assign Illegal     = illegal_q;
  assign State       = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_c;

  // An instruction retires on the edge leaving its final state
  assign retire_c = (state_q == S_WB_R)   || (state_q == S_WB_MEM) ||
                    (state_q == S_MEM_WR) || (state_q == S_BRANCH) ||
                    (state_q == S_WB_I);
  assign cnt_d    = retire_c ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign Instr_count = cnt_q;
`else
  assign Instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver walks a per-instruction
// state list taken from the instruction class, pushes the expected outputs of
// every cycle, and a monitor pops and compares one entry per clock.
module tb_multicycle_control;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run   = 1'b1;
  logic [5:0]  Opcode = 6'h00;
  logic [5:0]  Funct  = 6'h00;
  logic        PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst;
  logic        IorD, Mem_write, IR_write, ALU_src_a;
  logic [1:0]  ALU_src_b;
  logic [2:0]  ALU_control;
  logic        Illegal;
  logic [3:0]  State;
  logic [31:0] Instr_count;

  multicycle_control #(.STATE_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Opcode(Opcode), .Funct(Funct),
    .PC_write(PC_write), .Branch(Branch), .PC_src(PC_src),
    .Reg_write(Reg_write), .Mem_to_reg(Mem_to_reg), .Reg_dst(Reg_dst),
    .IorD(IorD), .Mem_write(Mem_write), .IR_write(IR_write),
    .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b), .ALU_control(ALU_control),
    .Illegal(Illegal), .State(State), .Instr_count(Instr_count)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw, br, pcs, rw, mtr, rd, iord, mw, irw, asa;
    logic [1:0]  asb;
    logic [2:0]  alu;
    logic        ill;
    logic [31:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] cnt_m  = 32'd0;
  logic [5:0]  r_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  function automatic logic [31:0] cnt_view(input logic [31:0] c);
`ifdef PERF_CNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  // Output table of each state code
  function automatic obs_t exp_rec(input int st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic [31:0] c);
    obs_t r;
    r = '0;
    r.st  = 4'(st);
    r.cnt = cnt_view(c);
    case (st)
      1:  begin r.irw = 1; r.asa = 1; r.asb = 2'd1; r.alu = 3'b010; r.pcw = 1; end
      2:  begin r.asa = 1; r.asb = 2'd2; r.alu = 3'b010; end
      3:  r.alu = alu_of_funct(fn);
      4:  begin r.rw = 1; r.rd = 1; end
      5:  begin r.asb = 2'd2; r.alu = 3'b010; end
      6:  r.iord = 1;
      7:  begin r.rw = 1; r.mtr = 1; end
      8:  begin r.iord = 1; r.mw = 1; end
      9:  begin r.alu = 3'b110; r.br = 1; r.pcs = 1; end
      10: if (op == 6'h0D) begin r.asb = 2'd3; r.alu = 3'b001; end
          else begin r.asb = 2'd2; r.alu = 3'b010; end
      11: r.rw = 1;
      12: r.ill = 1;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One instruction from FETCH; stop_after >= 0 truncates after that index
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int stop_after);
    int   seq[$];
    logic legal;
    seq   = {1, 2};
    legal = 1'b1;
    if (op == 6'h00 && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) seq = {seq, 3, 4};
    else if (op == 6'h23)                 seq = {seq, 5, 6, 7};
    else if (op == 6'h2B)                 seq = {seq, 5, 8};
    else if (op == 6'h04)                 seq = {seq, 9};
    else if (op == 6'h08 || op == 6'h0D)  seq = {seq, 10, 11};
    else begin
      legal = 1'b0;
      repeat (20) seq.push_back(12);
    end
    for (int i = 0; i < seq.size(); i++) begin
      if (stop_after >= 0 && i > stop_after) break;
      @(negedge Clock);
      Reset = 1'b0;
      Run   = (i == 0) ? 1'b1 : 1'($urandom);
      // Only the edge leaving DECODE sees the real instruction fields
      if (i == 2) begin Opcode = op; Funct = fn; end
      else begin Opcode = 6'($urandom); Funct = 6'($urandom); end
      exp_q.push_back(exp_rec(seq[i], op, fn, cnt_m));
    end
    if (legal && stop_after < 0) cnt_m = cnt_m + 32'd1;
  endtask

  // Asynchronous reset between clock edges, then idle cycles with Run low
  task automatic do_reset(input int idle_cycles);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_state",     32'(State),     32'd0);
    chk("async_illegal",   32'(Illegal),   32'd0);
    chk("async_reg_write", 32'(Reg_write), 32'd0);
    chk("async_mem_write", 32'(Mem_write), 32'd0);
    chk("async_count",     Instr_count,    32'd0);
    cnt_m = 32'd0;
    repeat (2) begin
      @(negedge Clock);
      Run = 1'($urandom);
      exp_q.push_back(exp_rec(0, 6'h00, 6'h00, cnt_m));
    end
    @(negedge Clock);
    Reset = 1'b0;
    Run   = 1'b0;
    exp_q.push_back(exp_rec(0, 6'h00, 6'h00, cnt_m));
    repeat (idle_cycles) begin
      @(negedge Clock);
      Run = 1'b0;
      exp_q.push_back(exp_rec(0, 6'h00, 6'h00, cnt_m));
    end
  endtask

  // Monitor: one expected entry per clock
  initial begin
    obs_t a, e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {State, PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst,
             IorD, Mem_write, IR_write, ALU_src_a, ALU_src_b, ALU_control,
             Illegal, Instr_count};
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs @%0t: state got %0d expected %0d, vector got %h expected %h",
                   $time, a.st, e.st, a, e);
        end
      end
    end
  end

  // Driver
  initial begin
    logic [5:0] op, fn;
    Reset = 1'b1;
    Run   = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      exp_q.push_back(exp_rec(0, 6'h00, 6'h00, cnt_m));
    end
    // Directed: R(sub), LW, SW, BEQ, ADDI, then ORI shows count 5
    run_instr(6'h00, 6'h22, -1);
    run_instr(6'h23, 6'h00, -1);
    run_instr(6'h2B, 6'h00, -1);
    run_instr(6'h04, 6'h00, -1);
    run_instr(6'h08, 6'h00, -1);
    run_instr(6'h0D, 6'h00, -1);
    for (int k = 0; k < 5; k++) run_instr(6'h00, r_fn[k], -1);

    // Random legal instruction stream with occasional resets
    for (int n = 0; n < 200; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin op = 6'h00; fn = r_fn[$urandom_range(0, 4)]; end
        5:       op = 6'h23;
        6:       op = 6'h2B;
        7:       op = 6'h04;
        8:       op = 6'h08;
        default: op = 6'h0D;
      endcase
      run_instr(op, fn, -1);
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(0, 3));
    end

    // Traps: unknown opcode, unknown funct, another unknown opcode
    run_instr(6'h3F, 6'h00, -1);
    do_reset(2);
    run_instr(6'h00, 6'h03, -1);
    do_reset(1);
    run_instr(6'h02, 6'h20, -1);
    do_reset(0);

    // Reset during MEM_RD of a load
    run_instr(6'h00, 6'h20, -1);
    run_instr(6'h23, 6'h00, 3);
    do_reset(2);
    run_instr(6'h2B, 6'h00, -1);

    repeat (3) @(posedge Clock);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
